// File: rtl/inst_axi_rd_bridge.sv
// Read-only bridge from the fetch SRAM-like port to an AXI3/AXI4 AR/R master.
// Optional macro INST_AXI_RD_BRIDGE_RRESP_CHK_EN adds inst_bus_err and nops faulting data.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID_VAL        = 4'd0,
  parameter int         MAX_OUTSTANDING = 2,
  parameter int         CNT_W           = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
`ifdef INST_AXI_RD_BRIDGE_RRESP_CHK_EN
  output logic        inst_bus_err,
`endif
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [0:0]       state_r;
  logic [31:0]      araddr_r;
  logic [1:0]       arsize_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;
  logic             rready_s;
  logic             r_hs_s;

  // Outputs are held quiet while reset is asserted so the reset cycle itself never handshakes.
  assign accept_s = inst_sram_req && !inst_sram_wr && (state_r == AR_IDLE)
                    && (cnt_r < MAX_CNT) && !reset;
  assign rready_s = (cnt_r != {CNT_W{1'b0}}) && !reset;
  assign r_hs_s   = rvalid && rready_s;

  // AR channel state and the address/size latched at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= AR_IDLE;
      araddr_r <= 32'h0;
      arsize_r <= 2'b00;
    end else begin
      case (state_r)
        AR_IDLE: begin
          if (accept_s) begin
            state_r  <= AR_BUSY;
            araddr_r <= inst_sram_addr;
            arsize_r <= inst_sram_size;
          end
        end
        AR_BUSY: begin
          if (arready) begin
            state_r <= AR_IDLE;
          end
        end
        default: state_r <= AR_IDLE;
      endcase
    end
  end

  // Outstanding-read counter: accepted requests not yet returned on R.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({accept_s, r_hs_s})
        2'b10:   cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign inst_sram_addr_ok = accept_s;
  assign inst_sram_data_ok = r_hs_s;
  assign rready            = rready_s;

  assign arid    = ARID_VAL;
  assign araddr  = araddr_r;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, arsize_r};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state_r == AR_BUSY);

`ifdef INST_AXI_RD_BRIDGE_RRESP_CHK_EN
  logic bus_err_s;
  assign bus_err_s    = r_hs_s && (rresp != 2'b00);
  assign inst_bus_err = bus_err_s;

  // Replace faulting return data with a nop so it can never execute.
  always_comb begin
    inst_sram_rdata = rdata;
    if (bus_err_s) begin
      inst_sram_rdata = 32'h0000_0000;
    end else begin
      inst_sram_rdata = rdata;
    end
  end

  logic unused_s;
  assign unused_s = ^{rid, rlast};
`else
  assign inst_sram_rdata = rdata;

  logic unused_s;
  assign unused_s = ^{rid, rlast, rresp};
`endif

endmodule
